// File: rtl/button_events.sv
// Purpose: turns a clean button level into press/release/long/repeat/double-click strobes.
// Latency: every strobe is registered, one cycle after the edge that samples its cause.
// Backpressure: none; the button is sampled every cycle and strobes are never held off.
module button_events #(
  parameter int CTR_WIDTH     = 16,
  parameter int LONG_CYCLES   = 40000,
  parameter int REPEAT_CYCLES = 10000,
  parameter int DCLICK_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic dclick_pulse,
  output logic held
);

  localparam longint CTR_SPAN = longint'(1) << CTR_WIDTH;

  generate
    if (LONG_CYCLES < 2 || longint'(LONG_CYCLES) > CTR_SPAN) begin : g_bad_long
      $error("button_events: LONG_CYCLES out of range for CTR_WIDTH");
    end
    if (REPEAT_CYCLES < 2 || longint'(REPEAT_CYCLES) > CTR_SPAN) begin : g_bad_repeat
      $error("button_events: REPEAT_CYCLES out of range for CTR_WIDTH");
    end
    if (DCLICK_CYCLES < 2 || longint'(DCLICK_CYCLES) > CTR_SPAN) begin : g_bad_dclick
      $error("button_events: DCLICK_CYCLES out of range for CTR_WIDTH");
    end
  endgenerate

  // Thresholds are compared against the timer value at the edge, so they sit one below the count.
  localparam logic [CTR_WIDTH-1:0] LONG_LAST   = CTR_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CTR_WIDTH-1:0] REPEAT_LAST = CTR_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [CTR_WIDTH-1:0] DCLICK_LAST = CTR_WIDTH'(DCLICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    HELD = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [CTR_WIDTH-1:0] timer, timer_nxt, timer_inc;
  logic                 second, second_nxt;
  logic                 btn_q;
  logic                 rise, fall;
  logic                 press_nxt, release_nxt, long_nxt, repeat_nxt, dclick_nxt, held_nxt;

  assign rise      = btn & ~btn_q;
  assign fall      = ~btn & btn_q;
  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    second_nxt  = second;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    dclick_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          press_nxt  = 1'b1;
          timer_nxt  = '0;
          second_nxt = 1'b0;
          state_nxt  = DOWN;
        end
      end

      DOWN: begin
        // A release on the threshold edge wins over the long-press event.
        if (fall) begin
          release_nxt = 1'b1;
          timer_nxt   = '0;
          second_nxt  = 1'b0;
          state_nxt   = second ? IDLE : GAP;
        end else if (timer == LONG_LAST) begin
          long_nxt  = 1'b1;
          timer_nxt = '0;
          state_nxt = HELD;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      HELD: begin
        if (fall) begin
          release_nxt = 1'b1;
          timer_nxt   = '0;
          state_nxt   = IDLE;
        end else if (timer == REPEAT_LAST) begin
          repeat_nxt = 1'b1;
          timer_nxt  = '0;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      GAP: begin
        // A press landing on the expiry edge still counts as the second click.
        if (rise) begin
          press_nxt  = 1'b1;
          dclick_nxt = 1'b1;
          timer_nxt  = '0;
          second_nxt = 1'b1;
          state_nxt  = DOWN;
        end else if (timer == DCLICK_LAST) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      default: begin
        timer_nxt  = '0;
        second_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase

    held_nxt = (state_nxt == HELD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      second        <= 1'b0;
      btn_q         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      dclick_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      second        <= second_nxt;
      btn_q         <= btn;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
      dclick_pulse  <= dclick_nxt;
      held          <= held_nxt;
    end
  end

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: timestamp-based reference model plus directed and random button traffic.
module tb_button_events;

  localparam int W    = 4;
  localparam int LONG = 8;
  localparam int REP  = 4;
  localparam int DCL  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, dclick_pulse, held;

  button_events #(
    .CTR_WIDTH    (W),
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP),
    .DCLICK_CYCLES(DCL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .dclick_pulse (dclick_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: edge counter plus timestamps of the current press and last short release.
  int n = 0;
  int m_prev = 0, m_down = 0, m_s = 0, m_second = 0, m_gap = 0, m_r = 0, m_held = 0;
  int mp = 0, mr = 0;

  // Per-scenario recorders of what the DUT produced.
  int cyc;
  int cnt_press, cnt_rel, cnt_long, cnt_rep, cnt_dcl;
  int first_press, first_long, first_held, rel_cyc, dcl_cyc;
  int q_rep[$];
  logic [5:0] obs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic b, input logic r, output logic [5:0] e);
    int dd;
    e = '0;
    if (r) begin
      m_prev = 0; m_down = 0; m_gap = 0; m_held = 0; m_second = 0;
    end else begin
      if (b && m_prev == 0) begin
        e[0] = 1'b1;
        mp++;
        if (m_gap != 0 && (n - m_r) <= DCL) begin
          e[4] = 1'b1;
          m_second = 1;
        end else begin
          m_second = 0;
        end
        m_gap = 0; m_down = 1; m_s = n;
      end else if (!b && m_prev != 0) begin
        e[1] = 1'b1;
        mr++;
        m_gap = ((n - m_s) <= LONG && m_second == 0) ? 1 : 0;
        m_r = n; m_down = 0; m_held = 0;
      end else if (m_down != 0) begin
        dd = n - m_s;
        if (dd == LONG) begin
          e[2] = 1'b1;
          m_held = 1;
        end else if (dd > LONG && (dd - LONG) % REP == 0) begin
          e[3] = 1'b1;
        end
      end
      e[5] = (m_held != 0);
      m_prev = b ? 1 : 0;
    end
    n++;
  endtask

  task automatic clear_rec();
    cyc = 0;
    cnt_press = 0; cnt_rel = 0; cnt_long = 0; cnt_rep = 0; cnt_dcl = 0;
    first_press = -1; first_long = -1; first_held = -1; rel_cyc = -1; dcl_cyc = -1;
    q_rep.delete();
    mp = 0; mr = 0;
  endtask

  task automatic step(input logic b, input logic r);
    logic [5:0] e;
    @(negedge clk);
    btn = b;
    rst = r;
    @(posedge clk);
    model_edge(b, r, e);
    #1;
    cyc++;
    obs = {held, dclick_pulse, repeat_pulse, long_pulse, release_pulse, press_pulse};
    check("outputs_vs_model", 32'(obs), 32'(e));
    check("pulse_exclusive", 32'($countones(obs[3:0]) <= 1), 32'd1);
    check("dclick_without_press", 32'(obs[4] & ~obs[0]), 32'd0);
    if (obs[0]) begin cnt_press++; if (first_press < 0) first_press = cyc; end
    if (obs[1]) begin cnt_rel++;   if (rel_cyc < 0) rel_cyc = cyc; end
    if (obs[2]) begin cnt_long++;  if (first_long < 0) first_long = cyc; end
    if (obs[3]) begin cnt_rep++;   q_rep.push_back(cyc); end
    if (obs[4]) begin cnt_dcl++;   if (dcl_cyc < 0) dcl_cyc = cyc; end
    if (obs[5] && first_held < 0) first_held = cyc;
  endtask

  task automatic run(input logic b, input int len);
    for (int i = 0; i < len; i++) step(b, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    clear_rec();
  endtask

  initial begin
    int total;
    int len;
    logic lvl;

    // Long hold: press, long, two repeats, release.
    do_reset();
    check("reset_outputs", 32'(obs), 32'd0);
    run(1'b1, 20);
    run(1'b0, 4);
    check("s1_press_cycle", first_press, 1);
    check("s1_long_cycle", first_long, 9);
    check("s1_held_from", first_held, 9);
    check("s1_repeat_count", q_rep.size(), 2);
    if (q_rep.size() >= 2) begin
      check("s1_repeat0_cycle", q_rep[0], 13);
      check("s1_repeat1_cycle", q_rep[1], 17);
    end
    check("s1_release_cycle", rel_cyc, 21);

    // Double click, then an immediate third press must be a plain press.
    do_reset();
    run(1'b1, 3); run(1'b0, 3); run(1'b1, 3); run(1'b0, 2); run(1'b1, 2); run(1'b0, 10);
    check("s2_press_count", cnt_press, 3);
    check("s2_release_count", cnt_rel, 3);
    check("s2_dclick_count", cnt_dcl, 1);
    check("s2_dclick_cycle", dcl_cyc, 7);
    check("s2_long_count", cnt_long, 0);

    // Gap too long: two plain presses.
    do_reset();
    run(1'b1, 3); run(1'b0, 10); run(1'b1, 3); run(1'b0, 10);
    check("s3_press_count", cnt_press, 2);
    check("s3_dclick_count", cnt_dcl, 0);

    // Gap boundary: re-press exactly at the expiry edge and one past it.
    for (int gap = DCL - 1; gap <= DCL + 1; gap++) begin
      do_reset();
      run(1'b1, 3); run(1'b0, gap); run(1'b1, 2); run(1'b0, 10);
      check("s3b_dclick_at_gap", cnt_dcl, (gap <= DCL) ? 1 : 0);
    end

    // Release on the long-press edge: release only, double-click window still opens.
    do_reset();
    run(1'b1, LONG); run(1'b0, 1); run(1'b1, 2); run(1'b0, 8);
    check("s4_long_count", cnt_long, 0);
    check("s4_dclick_count", cnt_dcl, 1);

    // One cycle longer: long fires and no window opens.
    do_reset();
    run(1'b1, LONG + 1); run(1'b0, 1); run(1'b1, 2); run(1'b0, 8);
    check("s4b_long_count", cnt_long, 1);
    check("s4b_dclick_count", cnt_dcl, 0);

    // Second press of a double-click held into long and repeat.
    do_reset();
    run(1'b1, 3); run(1'b0, 2); run(1'b1, 14); run(1'b0, 3);
    check("s6_dclick_count", cnt_dcl, 1);
    check("s6_long_count", cnt_long, 1);
    check("s6_repeat_count", cnt_rep, 1);

    // Reset during HELD with the button still down.
    do_reset();
    run(1'b1, 12);
    check("s5_held_before_rst", 32'(held), 32'd1);
    step(1'b1, 1'b1);
    check("s5_outputs_in_rst", 32'(obs), 32'd0);
    step(1'b1, 1'b0);
    check("s5_press_after_rst", 32'(press_pulse), 32'd1);
    run(1'b1, 2);
    check("s5_no_release", cnt_rel, 0);

    // Random traffic with occasional resets.
    do_reset();
    total = 0;
    lvl = 1'b0;
    while (total < 10000) begin
      len = $urandom_range(1, 16);
      lvl = ~lvl;
      for (int j = 0; j < len; j++) begin
        step(lvl, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      end
      total += len;
    end
    check("rand_press_count", cnt_press, mp);
    check("rand_release_count", cnt_rel, mr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 SHALL have parameter CTR_WIDTH, default 16, width of the shared event timer.
REQ-002 SHALL have parameter LONG_CYCLES, default 40000, cycles from press to long-press event.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000, cycles between auto-repeat events while held.
REQ-004 SHALL have parameter DCLICK_CYCLES, default 12000, double-click window measured from a short-press release.
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port btn  input  1  debounced, already-synchronized button level (1 = pressed).
REQ-008 SHALL have port press_pulse  output  1  one-cycle strobe on press.
REQ-009 SHALL have port release_pulse  output  1  one-cycle strobe on release.
REQ-010 SHALL have port long_pulse  output  1  one-cycle strobe when the long-press threshold is reached.
REQ-011 SHALL have port repeat_pulse  output  1  one-cycle auto-repeat strobe.
REQ-012 SHALL have port dclick_pulse  output  1  one-cycle strobe on the second press of a double-click.
REQ-013 SHALL have port held  output  1  level, 1 while in state HELD.

Function
REQ-014 SHALL implement states IDLE, DOWN, HELD and GAP; all outputs registered.
REQ-015 SHALL detect edges by comparing btn against a one-cycle-delayed copy btn_q; rise = btn & ~btn_q, fall = ~btn & btn_q.
REQ-016 SHALL assert each pulse for exactly one cycle, in the cycle after the edge at which the causing condition is sampled (1-cycle latency).
REQ-017 IDLE + rise: press_pulse, timer cleared, go to DOWN with second-click flag cleared.
REQ-018 DOWN, btn=1: timer increments; at the edge where the timer reaches LONG_CYCLES-1, long_pulse, timer cleared, go to HELD; long_pulse thus follows press_pulse by exactly LONG_CYCLES cycles.
REQ-019 HELD, btn=1: repeat_pulse every REPEAT_CYCLES cycles, i.e. at press_pulse time + LONG_CYCLES + k*REPEAT_CYCLES for k >= 1.
REQ-020 HELD + fall: release_pulse, go to IDLE; no double-click window opens after a long press.
REQ-021 DOWN + fall, second-click flag clear: release_pulse, timer cleared, go to GAP.
REQ-022 DOWN + fall, second-click flag set: release_pulse, go to IDLE (no triple-click chaining).
REQ-023 GAP + rise before the timer reaches DCLICK_CYCLES-1: press_pulse and dclick_pulse in the same cycle, timer cleared, go to DOWN with second-click flag set.
REQ-024 GAP with the timer reaching DCLICK_CYCLES-1 and no rise: go to IDLE silently; a later rise is an ordinary press.
REQ-025 A second press SHALL still produce long_pulse/repeat_pulse/HELD if held long enough.
REQ-026 Simultaneous events: a fall sampled at the same edge as a long or repeat threshold SHALL win, giving release_pulse only; a rise at the GAP expiry edge SHALL count as a double-click.
REQ-027 The timer SHALL saturate at all-ones and never wrap; LONG_CYCLES, REPEAT_CYCLES and DCLICK_CYCLES SHALL each be >= 2 and <= 2**CTR_WIDTH (elaboration-time check).
REQ-028 No two of press, release, long and repeat pulses SHALL assert in the same cycle; dclick_pulse coincides only with press_pulse.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, timer 0, second-click flag 0, btn_q 0, and all outputs 0, overriding any in-flight event.
REQ-030 If btn=1 on the first edge after rst falls, the block SHALL emit press_pulse (btn_q resets to 0).
REQ-031 Reset asserted mid-HELD SHALL emit no release_pulse.

Verification (LONG=8, REPEAT=4, DCLICK=6, CTR_WIDTH=4)
REQ-032 Hold btn=1 for 20 cycles from cycle 0, then 0 -> press_pulse at cycle 1, long_pulse at 9, repeat_pulse at 13, 17, held=1 from 9, release_pulse at 21.
REQ-033 btn=1 for 3 cycles, 0 for 3, 1 for 3 -> press, release, press+dclick same cycle, release, return to IDLE; no long_pulse.
REQ-034 btn=1 for 3 cycles, 0 for 10, 1 -> two plain presses, dclick_pulse never asserted.
REQ-035 btn falls at exactly the cycle where long_pulse would fire -> release_pulse only, state GAP.
REQ-036 Assert rst for 1 cycle during HELD with btn=1 -> all outputs 0, then press_pulse one cycle after rst deasserts.
REQ-037 Randomized btn over 10k cycles -> a scoreboard confirms REQ-028 exclusivity and a matching press/release count.
